// File: rtl/board_io_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_io_ctrl
// Purpose  : Board pin front end: tick generator, switch debouncer with edge
//            pulses, registered LEDs and a blanking/blinking 7-segment driver.
// Revision : 1.0  initial release
// ============================================================================
module board_io_ctrl #(
  parameter int unsigned DIVISOR         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned NUM_SW          = 9,
  parameter int unsigned NUM_LED         = 10,
  parameter int unsigned NUM_DIGITS      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SW-1:0]       sw,
  output logic [NUM_SW-1:0]       sw_db,
  output logic [NUM_SW-1:0]       sw_rise,
  output logic [NUM_SW-1:0]       sw_fall,
  output logic                    tick,
  input  logic [NUM_LED-1:0]      led_in,
  output logic [NUM_LED-1:0]      led,
  input  logic [4*NUM_DIGITS-1:0] hex_data,
  input  logic                    hex_load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blink_en,
  input  logic                    lzb_en,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int unsigned c_TICK_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(DIVISOR - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]          c_SEG_OFF   = 7'h7F;

  // --------------------------------------------------------------------------
  // Tick generator
  // --------------------------------------------------------------------------
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= (r_tick_cnt == c_TICK_LAST);
      if (r_tick_cnt == c_TICK_LAST) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  assign tick = r_tick;

  // --------------------------------------------------------------------------
  // Switch synchronise + debounce, one independent slice per bit
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < int'(NUM_SW); gi++) begin : g_sw
    logic              r_s1;
    logic              r_s2;
    logic              r_lvl;
    logic              r_rise;
    logic              r_fall;
    logic [c_DB_W-1:0] r_cnt;
    logic              w_diff;
    logic              w_accept;

    assign w_diff   = r_s2 ^ r_lvl;
    assign w_accept = w_diff && (r_cnt == c_DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_lvl  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1   <= sw[gi];
        r_s2   <= r_s1;
        r_rise <= w_accept && r_s2;
        r_fall <= w_accept && !r_s2;
        if (!w_diff || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_accept) begin
          r_lvl <= r_s2;
        end
      end
    end

    assign sw_db[gi]   = r_lvl;
    assign sw_rise[gi] = r_rise;
    assign sw_fall[gi] = r_fall;
  end

  // --------------------------------------------------------------------------
  // LEDs
  // --------------------------------------------------------------------------
  logic [NUM_LED-1:0] r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= led_in;
    end
  end

  assign led = r_led;

  // --------------------------------------------------------------------------
  // Seven-segment display
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_seg7(input logic [3:0] i_nib);
    logic [6:0] v_seg;
    case (i_nib)
      4'h0:    v_seg = 7'h40;
      4'h1:    v_seg = 7'h79;
      4'h2:    v_seg = 7'h24;
      4'h3:    v_seg = 7'h30;
      4'h4:    v_seg = 7'h19;
      4'h5:    v_seg = 7'h12;
      4'h6:    v_seg = 7'h02;
      4'h7:    v_seg = 7'h78;
      4'h8:    v_seg = 7'h00;
      4'h9:    v_seg = 7'h10;
      4'hA:    v_seg = 7'h08;
      4'hB:    v_seg = 7'h03;
      4'hC:    v_seg = 7'h46;
      4'hD:    v_seg = 7'h21;
      4'hE:    v_seg = 7'h06;
      default: v_seg = 7'h0E;
    endcase
    return v_seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] r_hex_data;
  logic                    r_phase;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [7*NUM_DIGITS-1:0] w_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex_data <= '0;
    end else if (hex_load) begin
      r_hex_data <= hex_data;
    end
  end

  // Phase 1 means visible; it idles visible whenever blinking is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b1;
    end else if (!blink_en) begin
      r_phase <= 1'b1;
    end else if (r_tick) begin
      r_phase <= ~r_phase;
    end
  end

  // w_upper_zero[i]: nibbles i..top are all zero, scanned from the top down.
  always_comb begin
    logic v_run;
    w_upper_zero = '0;
    v_run        = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      v_run           = v_run && (r_hex_data[4*i +: 4] == 4'h0);
      w_upper_zero[i] = v_run;
    end
  end

  always_comb begin
    logic v_blank;
    w_seg   = '1;
    v_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      v_blank = blank_mask[i]
             || (lzb_en && (i != 0) && w_upper_zero[i])
             || (blink_en && blink_mask[i] && !r_phase);
      w_seg[7*i +: 7] = v_blank ? c_SEG_OFF : f_seg7(r_hex_data[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_seg;
    end
  end

  assign hex = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_io_ctrl
// Purpose  : Scoreboard bench for board_io_ctrl with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_board_io_ctrl;

    localparam int K_TICK = 0;
    localparam int K_SWDB = 1;
    localparam int K_RISE = 2;
    localparam int K_FALL = 3;
    localparam int K_LED  = 4;
    localparam int K_HEX  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  sw = '0;
    logic [8:0]  sw_db, sw_rise, sw_fall;
    logic        tick;
    logic [9:0]  led_in = '0;
    logic [9:0]  led;
    logic [15:0] hex_data = '0;
    logic        hex_load = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        blink_en = 1'b0;
    logic        lzb_en = 1'b0;
    logic [27:0] hex;

    board_io_ctrl #(
        .DIVISOR(4), .DEBOUNCE_CYCLES(3), .NUM_SW(9), .NUM_LED(10), .NUM_DIGITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .sw_db(sw_db), .sw_rise(sw_rise),
        .sw_fall(sw_fall), .tick(tick), .led_in(led_in), .led(led),
        .hex_data(hex_data), .hex_load(hex_load), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .blink_en(blink_en), .lzb_en(lzb_en), .hex(hex)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    rel     = 0;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_TICK:  return 32'(tick);
            K_SWDB:  return 32'(sw_db);
            K_RISE:  return 32'(sw_rise);
            K_FALL:  return 32'(sw_fall);
            K_LED:   return 32'(led);
            default: return 32'(hex);
        endcase
    endfunction

    function automatic logic [31:0] hexv(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {4'h0, d3, d2, d1, d0};
    endfunction

    task automatic sb_push(input int kind, input logic [31:0] exp, input int delay,
                           input string name);
        item_t it;
        it.due  = edge_n + delay;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    // Monitor: compares every scoreboard entry that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_n) begin
                n_total++;
                if (observe(sb[i].kind) === sb[i].exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s at edge %0d: got %h, expected %h",
                             sb[i].name, edge_n, observe(sb[i].kind), sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        sb_push(K_TICK, 32'h0, 1, "reset_tick");
        sb_push(K_SWDB, 32'h0, 1, "reset_sw_db");
        sb_push(K_RISE, 32'h0, 1, "reset_sw_rise");
        sb_push(K_FALL, 32'h0, 1, "reset_sw_fall");
        sb_push(K_LED,  32'h0, 1, "reset_led");
        sb_push(K_HEX,  hexv(7'h7F, 7'h7F, 7'h7F, 7'h7F), 1, "reset_hex");
        @(negedge clk);

        rst_n  = 1'b1;
        rel    = edge_n;
        led_in = 10'h2AA;
        sb_push(K_LED,  32'h2AA, 1, "led_2aa");
        sb_push(K_TICK, 32'h0, 3, "tick_pre4");
        sb_push(K_TICK, 32'h1, 4, "tick_4");
        sb_push(K_TICK, 32'h0, 5, "tick_post4");
        sb_push(K_TICK, 32'h1, 8, "tick_8");
        sb_push(K_TICK, 32'h1, 12, "tick_12");
        repeat (13) @(negedge clk);

        rst_n = 1'b0;
        sb_push(K_TICK, 32'h0, 1, "tick_in_reset");
        sb_push(K_LED,  32'h0, 1, "led_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rel   = edge_n;
        sb_push(K_LED,  32'h2AA, 1, "led_after_reset");
        sb_push(K_TICK, 32'h0, 3, "tick_restart_pre");
        sb_push(K_TICK, 32'h1, 4, "tick_restart");
        repeat (6) @(negedge clk);

        sw = 9'h004;
        sb_push(K_SWDB, 32'h000, 4, "swdb_before_accept");
        sb_push(K_RISE, 32'h000, 4, "rise_before_accept");
        sb_push(K_SWDB, 32'h004, 5, "swdb_accept");
        sb_push(K_RISE, 32'h004, 5, "rise_pulse");
        sb_push(K_FALL, 32'h000, 5, "no_fall_on_rise");
        sb_push(K_RISE, 32'h000, 6, "rise_one_cycle");
        repeat (8) @(negedge clk);

        sw = 9'h005;
        sb_push(K_SWDB, 32'h004, 5, "glitch_swdb_a");
        sb_push(K_SWDB, 32'h004, 7, "glitch_swdb_b");
        sb_push(K_RISE, 32'h000, 5, "glitch_no_rise_a");
        sb_push(K_RISE, 32'h000, 6, "glitch_no_rise_b");
        repeat (2) @(negedge clk);
        sw = 9'h004;
        repeat (8) @(negedge clk);

        sw     = 9'h000;
        led_in = 10'h155;
        sb_push(K_LED,  32'h155, 1, "led_155");
        sb_push(K_SWDB, 32'h004, 4, "fall_swdb_hold");
        sb_push(K_SWDB, 32'h000, 5, "fall_swdb");
        sb_push(K_FALL, 32'h004, 5, "fall_pulse");
        sb_push(K_FALL, 32'h000, 6, "fall_one_cycle");
        repeat (8) @(negedge clk);

        hex_data = 16'h12AF;
        hex_load = 1'b1;
        sb_push(K_HEX, hexv(7'h40, 7'h40, 7'h40, 7'h40), 1, "hex_before_load");
        sb_push(K_HEX, hexv(7'h79, 7'h24, 7'h08, 7'h0E), 2, "hex_12af");
        @(negedge clk);
        hex_load = 1'b0;
        hex_data = 16'hFFFF;
        @(negedge clk);
        blank_mask = 4'b0010;
        sb_push(K_HEX, hexv(7'h79, 7'h24, 7'h7F, 7'h0E), 1, "hex_blank_d1");
        @(negedge clk);
        blank_mask = 4'b0000;
        sb_push(K_HEX, hexv(7'h79, 7'h24, 7'h08, 7'h0E), 1, "hex_unblank");
        @(negedge clk);

        lzb_en   = 1'b1;
        hex_data = 16'h0005;
        hex_load = 1'b1;
        sb_push(K_HEX, hexv(7'h7F, 7'h7F, 7'h7F, 7'h12), 2, "lzb_0005");
        @(negedge clk);
        hex_data = 16'h0000;
        sb_push(K_HEX, hexv(7'h7F, 7'h7F, 7'h7F, 7'h40), 2, "lzb_0000");
        @(negedge clk);
        hex_data = 16'h0300;
        sb_push(K_HEX, hexv(7'h7F, 7'h30, 7'h40, 7'h40), 2, "lzb_0300");
        @(negedge clk);
        hex_load = 1'b0;
        repeat (3) @(negedge clk);
        lzb_en = 1'b0;
        sb_push(K_HEX, hexv(7'h40, 7'h30, 7'h40, 7'h40), 1, "lzb_off_0300");
        @(negedge clk);

        hex_data = 16'h8888;
        hex_load = 1'b1;
        @(negedge clk);
        hex_load = 1'b0;
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h00), 1, "hex_8888");
        for (int i = 0; i < 8 && ((edge_n - rel) % 4) != 0; i++) @(negedge clk);
        blink_en   = 1'b1;
        blink_mask = 4'b0001;
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h00), 1, "blink_start_on");
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h7F), 2, "blink_off_a");
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h7F), 5, "blink_off_b");
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h00), 6, "blink_on_a");
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h00), 9, "blink_on_b");
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h7F), 10, "blink_off_c");
        repeat (11) @(negedge clk);
        blink_en = 1'b0;
        sb_push(K_HEX, hexv(7'h00, 7'h00, 7'h00, 7'h00), 1, "blink_disabled");
        repeat (2) @(negedge clk);
        blink_mask = 4'b0000;

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_push(K_LED, 32'h0, 0, "led_async_reset");
        sb_push(K_HEX, hexv(7'h7F, 7'h7F, 7'h7F, 7'h7F), 0, "hex_async_reset");
        #1;
        n_total++;
        if (led === 10'h000) begin
            n_pass++;
        end else begin
            $display("FAIL led_async_direct: got %h, expected 000", led);
        end
        n_total++;
        if (hex === {4{7'h7F}}) begin
            n_pass++;
        end else begin
            $display("FAIL hex_async_direct: got %h, expected all 7F", hex);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard not drained: %0d entries left", sb.size());
        end
        while (sb.size() != 0) begin
            n_total++;
            $display("FAIL %s: never checked, expected %h", sb[0].name, sb[0].exp);
            sb.delete(0);
        end
        if (n_pass != n_total) begin
            $display("FAIL %0d checks failed", n_total - n_pass);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
